// File: rtl/peripheral_bcd2bin_if.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_bcd2bin_if
// Description : J1 I/O bus bundle (chip select, address, strobes, data paths)
// Revision    : 1.0 - initial release
// ============================================================================
interface peripheral_bcd2bin_if;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;

    modport master (
        output d_in,
        output cs,
        output addr,
        output rd,
        output wr,
        input  d_out
    );

    modport slave (
        input  d_in,
        input  cs,
        input  addr,
        input  rd,
        input  wr,
        output d_out
    );
endinterface
`default_nettype wire

// File: rtl/peripheral_bcd2bin.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_bcd2bin
// Description : Memory-mapped packed-BCD to binary converter, one digit/clock
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_bcd2bin #(
    parameter int DIGITS = 4,
    parameter int RES_W  = 14
) (
    input  wire logic            clk,
    input  wire logic            rst,
    peripheral_bcd2bin_if.slave  bus
);

    localparam int                 c_IDX_W  = $clog2(DIGITS);
    localparam int                 c_BCD_W  = DIGITS * 4;
    localparam logic [c_IDX_W-1:0] c_IDX_MSD = c_IDX_W'(DIGITS - 1);

    localparam logic [3:0] c_ADDR_CTRL   = 4'h0;
    localparam logic [3:0] c_ADDR_BCD    = 4'h2;
    localparam logic [3:0] c_ADDR_RESULT = 4'h4;
    localparam logic [3:0] c_ADDR_STATUS = 4'h6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bus-side registers (falling edge)
    logic               r_enable;
    logic [c_BCD_W-1:0] r_bcd;
    logic [15:0]        r_d_out;

    // Conversion registers (rising edge)
    state_t             r_state;
    logic               r_enable_q;
    logic [c_BCD_W-1:0] r_sh;
    logic [RES_W-1:0]   r_acc;
    logic [c_IDX_W-1:0] r_idx;
    logic [RES_W-1:0]   r_result;
    logic               r_done;
    logic               r_busy;
    logic               r_err;

    logic               w_wr_ctrl;
    logic               w_wr_bcd;
    logic               w_rd_result;
    logic               w_rd_status;
    logic               w_start;
    logic               w_bcd_valid;
    logic [3:0]         w_digit;
    logic [RES_W-1:0]   w_acc_x10;
    logic [RES_W-1:0]   w_acc_next;

    assign w_wr_ctrl   = bus.cs && bus.wr && (bus.addr == c_ADDR_CTRL);
    assign w_wr_bcd    = bus.cs && bus.wr && (bus.addr == c_ADDR_BCD);
    assign w_rd_result = bus.cs && bus.rd && (bus.addr == c_ADDR_RESULT);
    assign w_rd_status = bus.cs && bus.rd && (bus.addr == c_ADDR_STATUS);

    assign w_start = r_enable && !r_enable_q &&
                     ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_bcd_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] > 4'd9) begin
                w_bcd_valid = 1'b0;
            end
        end
    end

    // Horner step: acc*10 built from shifts; 9999 fits, so no overflow guard.
    assign w_digit    = r_sh[{r_idx, 2'b00} +: 4];
    assign w_acc_x10  = (r_acc << 3) + (r_acc << 1);
    assign w_acc_next = w_acc_x10 + RES_W'(w_digit);

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_enable <= 1'b0;
            r_bcd    <= '0;
            r_d_out  <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_enable <= bus.d_in[0];
            end
            if (w_wr_bcd) begin
                r_bcd <= bus.d_in;
            end
            if (w_rd_result) begin
                r_d_out <= {{(16-RES_W){1'b0}}, r_result};
            end else if (w_rd_status) begin
                r_d_out <= {13'b0, r_err, r_busy, r_done};
            end else begin
                r_d_out <= '0;
            end
        end
    end

    assign bus.d_out = r_d_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_enable_q <= 1'b0;
            r_sh       <= '0;
            r_acc      <= '0;
            r_idx      <= c_IDX_MSD;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_enable_q <= r_enable;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_sh  <= r_bcd;
                        r_acc <= '0;
                        if (w_bcd_valid) begin
                            r_idx   <= c_IDX_MSD;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_err   <= 1'b0;
                            r_state <= S_CONV;
                        end else begin
                            r_err    <= 1'b1;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_result <= '0;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_CONV: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx - 1'b1;
                    if (r_idx == '0) begin
                        r_result <= w_acc_next;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
